vscale_md_issue: RTL and testbench

VSCALE_MD_ISSUE -- requirements
Module: vscale_md_issue

---
 rtl/vscale_md_issue_if.sv | 41 ++++
 rtl/vscale_md_issue.sv | 105 ++++++++++
 tb/tb_vscale_md_issue.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_md_issue_if.sv
// vscale_md_issue_if: decode, multiply/divide unit and writeback signals of the RV32M issue block
interface vscale_md_issue_if #(parameter int XPR_LEN = 32);
    logic               dx_valid;
    logic               dx_ready;
    logic [2:0]         dx_funct3;
    logic [4:0]         dx_rd;
    logic [XPR_LEN-1:0] dx_rs1_data;
    logic [XPR_LEN-1:0] dx_rs2_data;
    logic               kill;
    logic               busy;
    logic               md_req_valid;
    logic               md_req_ready;
    logic [1:0]         md_req_op;
    logic [1:0]         md_req_out_sel;
    logic               md_req_in_1_signed;
    logic               md_req_in_2_signed;
    logic [XPR_LEN-1:0] md_req_in_1;
    logic [XPR_LEN-1:0] md_req_in_2;
    logic               md_resp_valid;
    logic [XPR_LEN-1:0] md_resp_result;
    logic               wb_valid;
    logic [4:0]         wb_rd;
    logic [XPR_LEN-1:0] wb_data;
    logic               wb_ready;

    modport slave (
        input  dx_valid, dx_funct3, dx_rd, dx_rs1_data, dx_rs2_data, kill,
               md_req_ready, md_resp_valid, md_resp_result, wb_ready,
        output dx_ready, busy, md_req_valid, md_req_op, md_req_out_sel,
               md_req_in_1_signed, md_req_in_2_signed, md_req_in_1, md_req_in_2,
               wb_valid, wb_rd, wb_data
    );

    modport master (
        output dx_valid, dx_funct3, dx_rd, dx_rs1_data, dx_rs2_data, kill,
               md_req_ready, md_resp_valid, md_resp_result, wb_ready,
        input  dx_ready, busy, md_req_valid, md_req_op, md_req_out_sel,
               md_req_in_1_signed, md_req_in_2_signed, md_req_in_1, md_req_in_2,
               wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/vscale_md_issue.sv
// vscale_md_issue: issues one RV32M instruction to the multiply/divide unit and writes its result back
module vscale_md_issue #(
    parameter int XPR_LEN = 32
) (
    input logic              clk,
    input logic              reset,
    vscale_md_issue_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DRAIN} state_t;

    localparam logic [1:0] OP_MUL = 2'd0, OP_DIV = 2'd1, OP_REM = 2'd2;
    localparam logic [1:0] SEL_LO = 2'd0, SEL_HI = 2'd1, SEL_REM = 2'd2;
    localparam logic [XPR_LEN-1:0] MIN_NEG = {1'b1, {(XPR_LEN-1){1'b0}}};

    state_t             state_q, state_d;
    logic [4:0]         rd_q, rd_d;
    logic [1:0]         op_q, op_d, sel_q, sel_d;
    logic               s1_q, s1_d, s2_q, s2_d;
    logic [XPR_LEN-1:0] in1_q, in1_d, in2_q, in2_d, wb_data_q, wb_data_d;
    logic               accept, div_zero, overflow, special;
    logic [XPR_LEN-1:0] special_res;

    // divide-by-zero and signed overflow are resolved here without using the md unit
    always_comb begin
        accept      = bus.dx_valid && state_q == IDLE && !bus.kill;
        div_zero    = bus.dx_rs2_data == '0;
        overflow    = !bus.dx_funct3[0] && bus.dx_rs1_data == MIN_NEG && bus.dx_rs2_data == '1;
        special     = bus.dx_funct3[2] && (div_zero || overflow);
        special_res = div_zero ? (bus.dx_funct3[1] ? bus.dx_rs1_data : '1)
                               : (bus.dx_funct3[1] ? '0 : MIN_NEG);
    end

    // next state: capture and decode on accept, then request, wait, write back
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        op_d      = op_q;
        sel_d     = sel_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        wb_data_d = wb_data_q;
        if (accept) begin
            rd_d      = bus.dx_rd;
            in1_d     = bus.dx_rs1_data;
            in2_d     = bus.dx_rs2_data;
            op_d      = bus.dx_funct3[2] ? (bus.dx_funct3[1] ? OP_REM : OP_DIV) : OP_MUL;
            sel_d     = bus.dx_funct3[2] ? (bus.dx_funct3[1] ? SEL_REM : SEL_LO)
                                         : (bus.dx_funct3[1:0] == 2'd0 ? SEL_LO : SEL_HI);
            s1_d      = bus.dx_funct3[2] ? !bus.dx_funct3[0] : !(&bus.dx_funct3[1:0]);
            s2_d      = bus.dx_funct3[2] ? !bus.dx_funct3[0] : !bus.dx_funct3[1];
            wb_data_d = special ? special_res : wb_data_q;
            state_d   = special ? WB : REQ;
        end
        case (state_q)
            REQ:     state_d = bus.kill ? IDLE : (bus.md_req_ready ? WAIT : REQ);
            WAIT: begin
                state_d = bus.md_resp_valid ? (bus.kill ? IDLE : WB) : (bus.kill ? DRAIN : WAIT);
                if (bus.md_resp_valid && !bus.kill) wb_data_d = bus.md_resp_result;
            end
            WB:      state_d = bus.wb_ready ? IDLE : WB;
            DRAIN:   state_d = bus.md_resp_valid ? IDLE : DRAIN;
            default: ;
        endcase
    end

    // state and captured fields; reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            op_q      <= '0;
            sel_q     <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            in1_q     <= '0;
            in2_q     <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            op_q      <= op_d;
            sel_q     <= sel_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.dx_ready           = state_q == IDLE;
    assign bus.busy               = state_q != IDLE;
    assign bus.md_req_valid       = state_q == REQ;
    assign bus.md_req_op          = op_q;
    assign bus.md_req_out_sel     = sel_q;
    assign bus.md_req_in_1_signed = s1_q;
    assign bus.md_req_in_2_signed = s2_q;
    assign bus.md_req_in_1        = in1_q;
    assign bus.md_req_in_2        = in2_q;
    assign bus.wb_valid           = state_q == WB;
    assign bus.wb_rd              = rd_q;
    assign bus.wb_data            = wb_data_q;
endmodule

// File: tb/tb_vscale_md_issue.sv
// tb_vscale_md_issue: vector table, random transactions against an arithmetic model, and kill/reset corner cases
module tb_vscale_md_issue;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vscale_md_issue_if #(.XPR_LEN(32)) bus ();
    vscale_md_issue #(.XPR_LEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [2:0]  f;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wb;
        logic        sp;
    } vec_t;

    localparam logic [1:0] OPS  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    localparam logic [1:0] SELS [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
    localparam logic       S1T  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic       S2T  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    int    n_cmp = 0;
    int    n_bad = 0;
    string cur = "";
    vec_t  vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h", cur, name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            default:    p = '0;
        endcase
        if (!f[2]) return (f == 3'd0) ? p[31:0] : p[63:32];
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
        case (f)
            3'd4:    p = sa / sb;
            3'd5:    p = ua / ub;
            3'd6:    p = sa % sb;
            default: p = ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic present(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        bus.dx_valid = 1'b1;
        bus.dx_funct3 = f;
        bus.dx_rd = rd;
        bus.dx_rs1_data = a;
        bus.dx_rs2_data = b;
        tick();
        bus.dx_valid = 1'b0;
        bus.dx_funct3 = 3'($urandom);
        bus.dx_rd = 5'($urandom);
        bus.dx_rs1_data = $urandom;
        bus.dx_rs2_data = $urandom;
    endtask

    task automatic run_txn(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_wb, input logic sp, input int rdly, input int rspdly, input int wbdly);
        chk("dx_ready_before", bus.dx_ready, 1);
        present(f, rd, a, b);
        if (sp) begin
            chk("no_md_req", bus.md_req_valid, 0);
        end else begin
            for (int i = 0; i <= rdly; i++) begin
                chk("md_req_valid", bus.md_req_valid, 1);
                chk("md_req_op", bus.md_req_op, OPS[f]);
                chk("md_req_out_sel", bus.md_req_out_sel, SELS[f]);
                chk("in_1_signed", bus.md_req_in_1_signed, S1T[f]);
                chk("in_2_signed", bus.md_req_in_2_signed, S2T[f]);
                chk("md_req_in_1", bus.md_req_in_1, a);
                chk("md_req_in_2", bus.md_req_in_2, b);
                chk("wb_valid_in_req", bus.wb_valid, 0);
                bus.md_resp_valid = 1'($urandom);
                bus.md_resp_result = $urandom;
                if (i == rdly) bus.md_req_ready = 1'b1;
                tick();
                bus.md_req_ready = 1'b0;
                bus.md_resp_valid = 1'b0;
            end
            chk("md_req_valid_in_wait", bus.md_req_valid, 0);
            for (int i = 0; i < rspdly; i++) begin
                tick();
                chk("wb_valid_in_wait", bus.wb_valid, 0);
            end
            bus.md_resp_valid = 1'b1;
            bus.md_resp_result = exp_wb;
            tick();
            bus.md_resp_valid = 1'b0;
        end
        for (int i = 0; i <= wbdly; i++) begin
            chk("wb_valid", bus.wb_valid, 1);
            chk("wb_rd", bus.wb_rd, rd);
            chk("wb_data", bus.wb_data, exp_wb);
            chk("busy_in_wb", bus.busy, 1);
            bus.md_resp_valid = 1'($urandom);
            bus.md_resp_result = $urandom;
            if (i == wbdly) bus.wb_ready = 1'b1;
            tick();
            bus.wb_ready = 1'b0;
            bus.md_resp_valid = 1'b0;
        end
        chk("wb_valid_after", bus.wb_valid, 0);
        chk("dx_ready_after", bus.dx_ready, 1);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          r;

        vecs[0]  = '{3'd1, 5'd5,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[1]  = '{3'd5, 5'd3,  32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[2]  = '{3'd6, 5'd7,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[3]  = '{3'd4, 5'd8,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[4]  = '{3'd0, 5'd1,  32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 1'b0};
        vecs[5]  = '{3'd2, 5'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'd3, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[7]  = '{3'd7, 5'd11, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 1'b1};
        vecs[8]  = '{3'd6, 5'd12, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1};
        vecs[9]  = '{3'd4, 5'd13, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
        vecs[10] = '{3'd5, 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[11] = '{3'd7, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};

        reset = 1'b1;
        bus.dx_valid = 1'b0;
        bus.dx_funct3 = 3'd0;
        bus.dx_rd = 5'd0;
        bus.dx_rs1_data = 32'd0;
        bus.dx_rs2_data = 32'd0;
        bus.kill = 1'b0;
        bus.md_req_ready = 1'b0;
        bus.md_resp_valid = 1'b0;
        bus.md_resp_result = 32'd0;
        bus.wb_ready = 1'b0;
        tick();
        tick();
        cur = "reset";
        chk("dx_ready", bus.dx_ready, 1);
        chk("busy", bus.busy, 0);
        chk("wb_valid", bus.wb_valid, 0);
        chk("md_req_valid", bus.md_req_valid, 0);
        chk("wb_data", bus.wb_data, 0);
        chk("wb_rd", bus.wb_rd, 0);
        chk("md_req_in_1", bus.md_req_in_1, 0);
        chk("md_req_in_2", bus.md_req_in_2, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            cur = $sformatf("vec%0d", i);
            run_txn(vecs[i].f, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].wb, vecs[i].sp,
                    i == 0 ? 5 : i % 3, i % 4, i == 0 ? 4 : i % 2);
        end

        cur = "kill_idle";
        bus.kill = 1'b1;
        present(3'd0, 5'd2, 32'd5, 32'd6);
        bus.kill = 1'b0;
        chk("dx_ready", bus.dx_ready, 1);
        chk("busy", bus.busy, 0);

        cur = "kill_req";
        present(3'd0, 5'd2, 32'd5, 32'd6);
        chk("md_req_valid", bus.md_req_valid, 1);
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        chk("dx_ready", bus.dx_ready, 1);
        chk("md_req_valid", bus.md_req_valid, 0);
        chk("wb_valid", bus.wb_valid, 0);

        cur = "kill_wait";
        present(3'd0, 5'd4, 32'd9, 32'd9);
        bus.md_req_ready = 1'b1;
        tick();
        bus.md_req_ready = 1'b0;
        tick();
        tick();
        bus.kill = 1'b1;
        tick();
        chk("busy_drain", bus.busy, 1);
        for (int i = 0; i < 20; i++) begin
            chk("wb_valid_drain", bus.wb_valid, 0);
            chk("dx_ready_drain", bus.dx_ready, 0);
            if (i == 2) bus.kill = 1'b0;
            tick();
        end
        bus.md_resp_valid = 1'b1;
        bus.md_resp_result = 32'd81;
        tick();
        bus.md_resp_valid = 1'b0;
        chk("dx_ready", bus.dx_ready, 1);
        chk("wb_valid", bus.wb_valid, 0);

        cur = "kill_and_resp";
        present(3'd0, 5'd4, 32'd2, 32'd3);
        bus.md_req_ready = 1'b1;
        tick();
        bus.md_req_ready = 1'b0;
        bus.kill = 1'b1;
        bus.md_resp_valid = 1'b1;
        bus.md_resp_result = 32'd6;
        tick();
        bus.kill = 1'b0;
        bus.md_resp_valid = 1'b0;
        chk("dx_ready", bus.dx_ready, 1);
        chk("wb_valid", bus.wb_valid, 0);

        cur = "kill_wb";
        present(3'd5, 5'd6, 32'd7, 32'd0);
        bus.kill = 1'b1;
        tick();
        tick();
        bus.kill = 1'b0;
        chk("wb_valid", bus.wb_valid, 1);
        chk("wb_rd", bus.wb_rd, 6);
        chk("wb_data", bus.wb_data, 32'hFFFF_FFFF);
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        chk("dx_ready", bus.dx_ready, 1);

        cur = "reset_wait";
        present(3'd1, 5'd5, 32'hFFFF_FFFF, 32'd2);
        bus.md_req_ready = 1'b1;
        tick();
        bus.md_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("dx_ready", bus.dx_ready, 1);
        chk("busy", bus.busy, 0);
        chk("md_req_valid", bus.md_req_valid, 0);
        chk("wb_rd", bus.wb_rd, 0);
        chk("md_req_in_1", bus.md_req_in_1, 0);
        bus.md_resp_valid = 1'b1;
        bus.md_resp_result = 32'hFFFF_FFFF;
        tick();
        bus.md_resp_valid = 1'b0;
        chk("wb_valid_late_resp", bus.wb_valid, 0);
        chk("dx_ready_late_resp", bus.dx_ready, 1);
        chk("wb_data_late_resp", bus.wb_data, 0);

        for (int i = 0; i < 150; i++) begin
            cur = $sformatf("rand%0d", i);
            f = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 7);
            a = (r == 1) ? 32'h8000_0000 : $urandom;
            b = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFF_FFFF : (r == 2) ? 32'($urandom_range(1, 9)) : $urandom;
            run_txn(f, 5'($urandom), a, b, ref_res(f, a, b), is_special(f, a, b),
                    $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
